// File: rtl/fp_pkg.sv
// Shared types and constant builders for the sequential FP multiplier.
// Field layout is IEEE754-style {sign, exp, man}.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPK,
    MUL,
    NORM,
    RND
  } state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int word_w(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  function automatic int sig_w(input int mw);
    return mw + 1;
  endfunction

  // Magnitude only; callers prepend the sign.
  function automatic logic [63:0] inf_bits(input int ew, input int mw);
    return ((64'd1 << ew) - 64'd1) << mw;
  endfunction

  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    return inf_bits(ew, mw) | (64'd1 << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// RNE rounding, overflow/underflow detection and field packing.
// Purely combinational; special results bypass the datapath.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [MAN_W:0]         man_in,
  input  logic                   guard,
  input  logic                   rnd,
  input  logic                   sticky,
  input  logic                   spec_en,
  input  logic [EXP_W+MAN_W:0]   spec_res,
  input  logic [3:0]             spec_flg,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [3:0]             flags
);

  localparam int W  = word_w(EXP_W, MAN_W);
  localparam int M  = sig_w(MAN_W);
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0] INF =
    W'(inf_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << EXP_W) - 1);

  logic             inc;
  logic [M:0]       man_r;
  logic [MAN_W-1:0] frac;
  logic signed [EW-1:0] exp_f;
  logic             inexact;
  logic             ovf;
  logic             unf;

  always_comb begin
    inc     = guard & (rnd | sticky | man_in[0]);
    man_r   = {1'b0, man_in} + {{M{1'b0}}, inc};
    // Carry-out means 1.11..1 rounded up to 10.00..0.
    frac    = man_r[M] ? man_r[MAN_W:1]
                       : man_r[MAN_W-1:0];
    exp_f   = exp_in + (man_r[M] ? EW'(1) : EW'(0));
    inexact = guard | rnd | sticky;
    ovf     = !exp_f[EW-1] && (exp_f >= EMAX);
    unf     = exp_f[EW-1] || (exp_f == '0);

    res            = {sign, exp_f[EXP_W-1:0], frac};
    flags          = '0;
    flags[FLG_INX] = inexact;

    if (spec_en) begin
      res   = spec_res;
      flags = spec_flg;
    end else if (ovf) begin
      res            = {sign, INF[W-2:0]};
      flags          = '0;
      flags[FLG_OVF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end else if (unf) begin
      res            = {sign, {(W-1){1'b0}}};
      flags          = '0;
      flags[FLG_UNF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE754-style multiplier: radix-2 shift-add mantissa
// product, fixed latency for every operand class, flush-to-zero.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [EXP_W+MAN_W:0] data1_in,
  input  logic [EXP_W+MAN_W:0] data2_in,
  input  logic                 trig,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] data_out,
  output logic                 vld,
  output logic [3:0]           exc_flags
);

  localparam int W  = word_w(EXP_W, MAN_W);
  localparam int M  = sig_w(MAN_W);
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(M + 1);
  localparam logic [W-1:0] QNAN =
    W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [W-1:0] INF =
    W'(inf_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS_S =
    EW'(bias(EXP_W));

  state_t state;
  state_t nxt;

  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;
  logic                 sgn;
  logic signed [EW-1:0] exp_s;
  logic [M-1:0]         ma;
  logic [2*M-1:0]       acc;
  logic [CW-1:0]        cnt;
  logic                 sp_en_q;
  logic [W-1:0]         sp_res_q;
  logic [3:0]           sp_flg_q;
  logic signed [EW-1:0] nexp;
  logic [M-1:0]         nman;
  logic                 ng;
  logic                 nr;
  logic                 ns;
  logic                 rnd_ph;
  logic [W-1:0]         res_q;
  logic [3:0]           flg_q;

  logic             a_s;
  logic             b_s;
  logic [EXP_W-1:0] a_e;
  logic [EXP_W-1:0] b_e;
  logic [MAN_W-1:0] a_m;
  logic [MAN_W-1:0] b_m;
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic sgn_c;
  logic sp_en;
  logic [W-1:0] sp_res;
  logic [3:0]   sp_flg;
  logic [M:0]   sum;
  logic [W-1:0] rp_res;
  logic [3:0]   rp_flg;

  assign a_s = op_a[W-1];
  assign b_s = op_b[W-1];
  assign a_e = op_a[W-2 -: EXP_W];
  assign b_e = op_b[W-2 -: EXP_W];
  assign a_m = op_a[MAN_W-1:0];
  assign b_m = op_b[MAN_W-1:0];

  // Subnormals share the zero class: exp == 0 flushes to zero.
  always_comb begin
    a_nan  = (&a_e) & (|a_m);
    a_inf  = (&a_e) & ~(|a_m);
    a_zero = ~(|a_e);
    b_nan  = (&b_e) & (|b_m);
    b_inf  = (&b_e) & ~(|b_m);
    b_zero = ~(|b_e);
    sgn_c  = a_s ^ b_s;
    sp_en  = 1'b0;
    sp_res = '0;
    sp_flg = '0;
    if (a_nan | b_nan) begin
      sp_en  = 1'b1;
      sp_res = QNAN;
    end else if ((a_inf & b_zero) |
                 (b_inf & a_zero)) begin
      sp_en           = 1'b1;
      sp_res          = QNAN;
      sp_flg[FLG_INV] = 1'b1;
    end else if (a_inf | b_inf) begin
      sp_en  = 1'b1;
      sp_res = {sgn_c, INF[W-2:0]};
    end else if (a_zero | b_zero) begin
      sp_en  = 1'b1;
      sp_res = {sgn_c, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    sum = {1'b0, acc[2*M-1:M]} +
          (acc[0] ? {1'b0, ma} : '0);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (trig) nxt = UNPK;
      UNPK: nxt = MUL;
      MUL:  if (cnt == CW'(MAN_W)) nxt = NORM;
      NORM: nxt = RND;
      RND:  if (rnd_ph) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= nxt;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      op_a      <= '0;
      op_b      <= '0;
      sgn       <= 1'b0;
      exp_s     <= '0;
      ma        <= '0;
      acc       <= '0;
      cnt       <= '0;
      sp_en_q   <= 1'b0;
      sp_res_q  <= '0;
      sp_flg_q  <= '0;
      nexp      <= '0;
      nman      <= '0;
      ng        <= 1'b0;
      nr        <= 1'b0;
      ns        <= 1'b0;
      rnd_ph    <= 1'b0;
      res_q     <= '0;
      flg_q     <= '0;
      data_out  <= '0;
      exc_flags <= '0;
      vld       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            op_a <= data1_in;
            op_b <= data2_in;
            busy <= 1'b1;
          end
        end
        UNPK: begin
          sgn      <= sgn_c;
          exp_s    <= $signed({2'b00, a_e}) +
                      $signed({2'b00, b_e}) - BIAS_S;
          ma       <= {1'b1, a_m};
          acc      <= {{M{1'b0}}, 1'b1, b_m};
          cnt      <= '0;
          sp_en_q  <= sp_en;
          sp_res_q <= sp_res;
          sp_flg_q <= sp_flg;
        end
        MUL: begin
          acc <= {sum, acc[M-1:1]};
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          if (acc[2*M-1]) begin
            nman <= acc[2*M-1 -: M];
            ng   <= acc[M-1];
            nr   <= acc[M-2];
            ns   <= |acc[M-3:0];
            nexp <= exp_s + EW'(1);
          end else begin
            nman <= acc[2*M-2 -: M];
            ng   <= acc[M-2];
            nr   <= acc[M-3];
            ns   <= |acc[M-4:0];
            nexp <= exp_s;
          end
        end
        RND: begin
          // Rounded word is registered before release so the
          // increment chain never reaches the output pins.
          if (!rnd_ph) begin
            res_q  <= rp_res;
            flg_q  <= rp_flg;
            rnd_ph <= 1'b1;
          end else begin
            data_out  <= res_q;
            exc_flags <= flg_q;
            vld       <= 1'b1;
            busy      <= 1'b0;
            rnd_ph    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign     (sgn),
    .exp_in   (nexp),
    .man_in   (nman),
    .guard    (ng),
    .rnd      (nr),
    .sticky   (ns),
    .spec_en  (sp_en_q),
    .spec_res (sp_res_q),
    .spec_flg (sp_flg_q),
    .res      (rp_res),
    .flags    (rp_flg)
  );

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed vector bench for fp_mul_seq at EXP_W=8, MAN_W=23.
// Checks results, flags, latency, busy and reset behaviour.
module tb_fp_mul_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        trig = 1'b0;
  logic [31:0] data1_in = '0;
  logic [31:0] data2_in = '0;
  logic        busy;
  logic        vld;
  logic [31:0] data_out;
  logic [3:0]  exc_flags;

  always #5 sys_clk = ~sys_clk;

  fp_mul_seq #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .data1_in  (data1_in),
    .data2_in  (data2_in),
    .trig      (trig),
    .busy      (busy),
    .data_out  (data_out),
    .vld       (vld),
    .exc_flags (exc_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; trig is sampled on the next posedge.
  task automatic run(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] prev,
                     output logic [31:0] res,
                     output logic [3:0]  flg,
                     output int lat);
    data1_in = a;
    data2_in = b;
    trig = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    trig = 1'b0;
    lat = -1;
    res = 'x;
    flg = 'x;
    chk("busy_set", 32'(busy), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) chk("hold", data_out, prev);
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (vld) begin
        lat = n;
        res = data_out;
        flg = exc_flags;
        break;
      end
    end
  endtask

  logic [31:0] r;
  logic [3:0]  f;
  int          lat;
  logic [31:0] prev;
  int          nv;
  int          first;

  initial begin
    vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'h0};
    vt[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0};
    vt[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
    vt[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
    vt[4]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0};
    vt[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5};
    vt[6]  = '{32'h00800000, 32'h3E800000, 32'h00000000, 4'h3};
    vt[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'h0};
    vt[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0};
    vt[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'h0};
    vt[10] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0};
    vt[11] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
    vt[12] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1};
    vt[13] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0};
    vt[14] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
    vt[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0};
    vt[16] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'h0};
    vt[17] = '{32'h80000001, 32'h7F800000, 32'h7FC00000, 4'h8};
    // underflow flags are {0,0,1,1} = 4'h3
    vt[6].flg = 4'h3;

    repeat (2) @(negedge sys_clk);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_flags", 32'(exc_flags), 32'd0);
    sys_rst = 1'b0;

    prev = '0;
    for (int i = 0; i < NV; i++) begin
      run(vt[i].a, vt[i].b, prev, r, f, lat);
      chk($sformatf("v%0d_res", i), r, vt[i].res);
      chk($sformatf("v%0d_flg", i), 32'(f), 32'(vt[i].flg));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd28);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      prev = vt[i].res;
    end

    // Second trig five cycles in must be ignored.
    data1_in = 32'h40000000;
    data2_in = 32'h40400000;
    trig = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    trig = 1'b0;
    nv = 0;
    first = -1;
    r = '0;
    f = '0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin
        data1_in = 32'h7F800000;
        data2_in = 32'h00000000;
        trig = 1'b1;
      end else begin
        trig = 1'b0;
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (vld) begin
        nv++;
        if (first < 0) begin
          first = n;
          r = data_out;
          f = exc_flags;
        end
      end
    end
    chk("ign_count", 32'(nv), 32'd1);
    chk("ign_lat", 32'(first), 32'd28);
    chk("ign_res", r, 32'h40C00000);
    chk("ign_flg", 32'(f), 32'd0);

    // Reset mid-MUL discards the operation.
    data1_in = 32'h3F800001;
    data2_in = 32'h3F800001;
    trig = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    trig = 1'b0;
    repeat (9) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("mrst_vld", 32'(vld), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_data", data_out, 32'd0);
    chk("mrst_flags", 32'(exc_flags), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    run(32'hC0000000, 32'h40400000, 32'd0, r, f, lat);
    chk("post_res", r, 32'hC0C00000);
    chk("post_flg", 32'(f), 32'd0);
    chk("post_lat", 32'(lat), 32'd28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
